tetris_render_pipe: RTL
=======================

Name: tetris_render_pipe

Overview:
Pipelined, parametrised pixel renderer for the Tetris VGA path. It takes the raster pixel coordinate and the game-state and cell-occupancy flags, and issues synchronous ROM addresses for the tile and overlay images. One pixel per clock, it returns a registered 12-bit RGB colour aligned with a valid strobe. Unlike the earlier combinational shader it has configurable board geometry, a fixed pipeline latency that matches one-cycle block ROMs, a pause state with a blinking overlay, and a frame-counted line-clear flash.

Parameters:
CELL, 24, cell edge in pixels (tile ROM is CELL*CELL words).
BOARD_X0, 200, left pixel of board.
BOARD_Y0, 0, top pixel of board.
COLS, 10, board columns.
ROWS, 20, board rows.
BORDER, 3, border thickness in pixels outside the board on left, right, top and bottom.
OVL_X0, 170, overlay left.
OVL_Y0, 140, overlay top.
OVL_W, 300, overlay width.
OVL_H, 200, overlay height.
BLINK_FRAMES, 30, pause-overlay on/off half period in frames.
FLASH_FRAMES, 24, line-clear flash duration in frames.
BORDER_RGB, 12'h79b, border colour.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_valid  in  1  x/y valid this cycle
x  in  10  pixel column
y  in  9  pixel row
frame_start  in  1  one-cycle pulse at start of each frame
state  in  2  0 cover, 1 play, 2 over, 3 pause
shape  in  3  active piece colour index 0..7
is_position  in  1  pixel lies in active piece
is_occupy  in  1  pixel lies in locked cell
clear_pulse  in  1  start line-clear flash
clear_mask  in  ROWS  rows being cleared (bit r = board row r)
tile_addr  out  $clog2(CELL*CELL)+3  {shape_sel[2:0], yr*CELL+xr} to tile ROM
ovl_addr  out  17  overlay ROM address
ovl_sel  out  1  0 cover image, 1 game-over/pause image
tile_rgb  in  12  tile ROM data, one cycle after tile_addr
ovl_rgb  in  12  overlay ROM data, one cycle after ovl_addr
color  out  12  pixel colour
color_valid  out  1  color valid

Behaviour:
- Reset: color=0, color_valid=0, tile_addr=0, ovl_addr=0, ovl_sel=0. Pipeline valids, frame counter, blink phase and flash counter are all cleared. Reset mid-frame discards in-flight pixels.
- Latency is fixed at 3 cycles from pix_valid to color_valid. Throughput is 1 pixel per clock with no stalls. Invalid input pixels propagate as bubbles.
- S1 (registered):
  - dx = x-BOARD_X0, dy = y-BOARD_Y0.
  - in_board = 0<=dx<COLS*CELL and 0<=dy<ROWS*CELL.
  - xr = dx%CELL, yr = dy%CELL, row = dy/CELL.
  - in_border = pixel lies within BORDER pixels outside the board edges.
  - in_ovl = overlay window test.
  - Flags and state are captured for use in later stages.
- S1 outputs:
  - tile_addr uses shape_sel = shape if is_position, else 7 (gray) if is_occupy.
  - ovl_addr = (x-OVL_X0)+OVL_W*(y-OVL_Y0) when in_ovl, else 0.
  - ovl_sel = (state!=0).
- S2: ROM data returns. The S1 flags are delayed one stage to stay aligned.
- S3 colour priority (registered):
  - state 0: in_ovl ? ovl_rgb : 0.
  - state 2: in_ovl ? ovl_rgb : 0.
  - state 1 or 3, evaluated in order:
    - If state==3, blink_on and in_ovl: ovl_rgb.
    - Else if is_position or is_occupy:
      - If flash_active, clear_mask[row] and flash_phase: 12'hFFF.
      - Otherwise tile_rgb.
    - Else if in_border: BORDER_RGB.
    - Otherwise 0.
- Frame counter: advances on frame_start. blink_on toggles every BLINK_FRAMES frames while state==3. It is forced to 1 on entry to pause, so the overlay is visible the first frame.
- Flash:
  - clear_pulse latches clear_mask and loads flash_cnt=FLASH_FRAMES.
  - Each frame_start decrements flash_cnt while it is nonzero. flash_active = (flash_cnt!=0).
  - flash_phase = flash_cnt[2], so the flash toggles every 4 frames.
  - A clear_pulse during an active flash reloads both the mask and the counter (restart).
  - clear_pulse and frame_start in the same cycle: the load wins and no decrement happens that cycle.
  - Leaving states 1/3 clears the flash.
- Row index is only used when in_board. Out-of-board rows never index clear_mask.
- Coordinates with x<BOARD_X0 produce a negative dx, which must evaluate as out-of-board. Do not wrap the unsigned value.

Test Plan:
- Reset then pix_valid stream x=0..639, y=10, state=1, no flags: color_valid rises 3 cycles after first pix_valid. Pixels at x=197..199 and 440..442 give 12'h79b; all other pixels give 0.
- x=230, y=50, is_position=1, shape=2: tile_addr = {3'd2, 2*24+6=54}. color equals tile_rgb returned the following cycle, 3 cycles after input.
- state=0, x=170, y=140, then x=469, y=339: ovl_addr is 0, then 59999. ovl_sel=0 and color=ovl_rgb. Pixel x=169 gives 0.
- state=3 for 61 frames, overlay pixel driven every frame: ovl_rgb is shown for frames 0-29, 0 for frames 30-59, and ovl_rgb again at frame 60.
- clear_pulse with clear_mask bit 19 set, occupied pixel at y=470: alternates 12'hFFF / tile_rgb every 4 frames and returns to tile_rgb after 24 frames. A second clear_pulse at frame 10 extends the flash to frame 34.
- Assert rst for one cycle mid-line while pix_valid is held high: color_valid=0 for the next 3 cycles, and flash and blink state are cleared.

Source files
------------

// File: rtl/tetris_render_pipe.sv
// -----------------------------------------------------------------------------
// tetris_render_pipe
// Three-stage pixel renderer for the Tetris VGA path. It produces one pixel per
// clock with no stalls.
//   S1: Geometry decode (board, border and overlay window tests). Registers the
//       tile and overlay ROM addresses.
//   S2: Synchronous ROMs return data. The S1 flags are delayed to stay aligned.
//   S3: Colour priority mux. Registers color and color_valid.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pix_valid, x, y    raster coordinate, qualified by pix_valid
//   frame_start        one-cycle pulse at the start of each frame
//   state              0 cover, 1 play, 2 over, 3 pause
//   shape              colour index of the active piece
//   is_position        pixel lies in the active piece
//   is_occupy          pixel lies in a locked cell
//   clear_pulse        starts a line-clear flash on the rows in clear_mask
//   clear_mask         rows being cleared
//   tile_addr          {shape_sel, yr*CELL+xr} to the tile ROM
//   ovl_addr, ovl_sel  overlay ROM address and image select
//   tile_rgb, ovl_rgb  ROM data, one cycle after the address
//   color, color_valid rendered pixel, 3 cycles after pix_valid
// -----------------------------------------------------------------------------
module tetris_render_pipe #(
    parameter int          CELL         = 24,
    parameter int          BOARD_X0     = 200,
    parameter int          BOARD_Y0     = 0,
    parameter int          COLS         = 10,
    parameter int          ROWS         = 20,
    parameter int          BORDER       = 3,
    parameter int          OVL_X0       = 170,
    parameter int          OVL_Y0       = 140,
    parameter int          OVL_W        = 300,
    parameter int          OVL_H        = 200,
    parameter int          BLINK_FRAMES = 30,
    parameter int          FLASH_FRAMES = 24,
    parameter logic [11:0] BORDER_RGB   = 12'h79b
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pix_valid,
    input  logic [9:0]                       x,
    input  logic [8:0]                       y,
    input  logic                             frame_start,
    input  logic [1:0]                       state,
    input  logic [2:0]                       shape,
    input  logic                             is_position,
    input  logic                             is_occupy,
    input  logic                             clear_pulse,
    input  logic [ROWS-1:0]                  clear_mask,
    output logic [$clog2(CELL*CELL)+3-1:0]   tile_addr,
    output logic [16:0]                      ovl_addr,
    output logic                             ovl_sel,
    input  logic [11:0]                      tile_rgb,
    input  logic [11:0]                      ovl_rgb,
    output logic [11:0]                      color,
    output logic                             color_valid
);

    localparam int OW  = $clog2(CELL*CELL);
    localparam int TAW = OW + 3;
    localparam int RW  = $clog2(ROWS);
    localparam int BW  = $clog2(BLINK_FRAMES);
    localparam int FW  = $clog2(FLASH_FRAMES + 1);

    // Geometry working values. These are signed so that pixels left of or
    // above the board give negative offsets instead of wrapping.
    int             dx_s, dy_s, xr_s, yr_s, row_s, ovl_off_s;
    logic           in_board_s, in_border_s, in_ovl_s;
    logic [2:0]     shape_sel_s;

    // Stage 1 registers
    logic           v1_q, v1_d;
    logic           in_board1_q, in_board1_d;
    logic           in_border1_q, in_border1_d;
    logic           in_ovl1_q, in_ovl1_d;
    logic [RW-1:0]  row1_q, row1_d;
    logic           pos1_q, pos1_d;
    logic           occ1_q, occ1_d;
    logic [1:0]     state1_q, state1_d;
    logic [TAW-1:0] tile_addr_q, tile_addr_d;
    logic [16:0]    ovl_addr_q, ovl_addr_d;
    logic           ovl_sel_q, ovl_sel_d;

    // Stage 2 registers
    logic           v2_q, in_board2_q, in_border2_q, in_ovl2_q, pos2_q, occ2_q;
    logic [RW-1:0]  row2_q;
    logic [1:0]     state2_q;

    // Stage 3 registers
    logic [11:0]    color_q, color_d;
    logic           color_valid_q, color_valid_d;

    // Frame-based control state
    logic [1:0]     prev_state_q, prev_state_d;
    logic           blink_on_q, blink_on_d;
    logic [BW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
    logic [ROWS-1:0] flash_mask_q, flash_mask_d;
    logic           pause_entry_s, flash_hit_s;

    // Stage 1 decode: board, border, overlay window and ROM addresses
    always_comb begin
        dx_s        = int'(x) - BOARD_X0;
        dy_s        = int'(y) - BOARD_Y0;
        in_board_s  = (dx_s >= 0) && (dx_s < COLS*CELL) &&
                      (dy_s >= 0) && (dy_s < ROWS*CELL);
        in_border_s = !in_board_s &&
                      (dx_s >= -BORDER) && (dx_s < COLS*CELL + BORDER) &&
                      (dy_s >= -BORDER) && (dy_s < ROWS*CELL + BORDER);
        in_ovl_s    = (int'(x) >= OVL_X0) && (int'(x) < OVL_X0 + OVL_W) &&
                      (int'(y) >= OVL_Y0) && (int'(y) < OVL_Y0 + OVL_H);
        // Only in-board offsets are meaningful; outside the board the cell
        // coordinates are forced to 0 so the row never indexes clear_mask.
        if (in_board_s) begin
            xr_s  = dx_s % CELL;
            yr_s  = dy_s % CELL;
            row_s = dy_s / CELL;
        end else begin
            xr_s  = 0;
            yr_s  = 0;
            row_s = 0;
        end
        if (in_ovl_s) begin
            ovl_off_s = (int'(x) - OVL_X0) + OVL_W * (int'(y) - OVL_Y0);
        end else begin
            ovl_off_s = 0;
        end
        if (is_position) begin
            shape_sel_s = shape;
        end else if (is_occupy) begin
            shape_sel_s = 3'd7;
        end else begin
            shape_sel_s = 3'd0;
        end
        v1_d         = pix_valid;
        in_board1_d  = in_board_s;
        in_border1_d = in_border_s;
        in_ovl1_d    = in_ovl_s;
        row1_d       = RW'(row_s);
        pos1_d       = is_position;
        occ1_d       = is_occupy;
        state1_d     = state;
        tile_addr_d  = {shape_sel_s, OW'(yr_s * CELL + xr_s)};
        ovl_addr_d   = 17'(ovl_off_s);
        ovl_sel_d    = (state != 2'd0);
    end

    // Stage 1 registers, including the ROM address outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            in_board1_q  <= 1'b0;
            in_border1_q <= 1'b0;
            in_ovl1_q    <= 1'b0;
            row1_q       <= '0;
            pos1_q       <= 1'b0;
            occ1_q       <= 1'b0;
            state1_q     <= 2'd0;
            tile_addr_q  <= '0;
            ovl_addr_q   <= 17'd0;
            ovl_sel_q    <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            in_board1_q  <= in_board1_d;
            in_border1_q <= in_border1_d;
            in_ovl1_q    <= in_ovl1_d;
            row1_q       <= row1_d;
            pos1_q       <= pos1_d;
            occ1_q       <= occ1_d;
            state1_q     <= state1_d;
            tile_addr_q  <= tile_addr_d;
            ovl_addr_q   <= ovl_addr_d;
            ovl_sel_q    <= ovl_sel_d;
        end
    end

    // Stage 2: delay the flags while the ROMs look up their data
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q         <= 1'b0;
            in_board2_q  <= 1'b0;
            in_border2_q <= 1'b0;
            in_ovl2_q    <= 1'b0;
            row2_q       <= '0;
            pos2_q       <= 1'b0;
            occ2_q       <= 1'b0;
            state2_q     <= 2'd0;
        end else begin
            v2_q         <= v1_q;
            in_board2_q  <= in_board1_q;
            in_border2_q <= in_border1_q;
            in_ovl2_q    <= in_ovl1_q;
            row2_q       <= row1_q;
            pos2_q       <= pos1_q;
            occ2_q       <= occ1_q;
            state2_q     <= state1_q;
        end
    end

    // Stage 3 colour priority. Bubbles produce colour 0.
    always_comb begin
        flash_hit_s   = (flash_cnt_q != '0) && in_board2_q &&
                        flash_mask_q[row2_q] && flash_cnt_q[2];
        color_valid_d = v2_q;
        color_d       = 12'h000;
        if (v2_q) begin
            case (state2_q)
                2'd0, 2'd2: begin
                    if (in_ovl2_q) begin
                        color_d = ovl_rgb;
                    end else begin
                        color_d = 12'h000;
                    end
                end
                2'd1, 2'd3: begin
                    if ((state2_q == 2'd3) && blink_on_q && in_ovl2_q) begin
                        color_d = ovl_rgb;
                    end else if (pos2_q || occ2_q) begin
                        if (flash_hit_s) begin
                            color_d = 12'hfff;
                        end else begin
                            color_d = tile_rgb;
                        end
                    end else if (in_border2_q) begin
                        color_d = BORDER_RGB;
                    end else begin
                        color_d = 12'h000;
                    end
                end
                default: color_d = 12'h000;
            endcase
        end else begin
            color_d = 12'h000;
        end
    end

    // Stage 3 output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q       <= 12'h000;
            color_valid_q <= 1'b0;
        end else begin
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    // Pause blink and line-clear flash sequencing
    always_comb begin
        prev_state_d  = state;
        pause_entry_s = (state == 2'd3) && (prev_state_q != 2'd3);
        blink_on_d    = blink_on_q;
        frame_cnt_d   = frame_cnt_q;
        // Entering pause restarts the blink with the overlay visible
        if (pause_entry_s) begin
            blink_on_d  = 1'b1;
            frame_cnt_d = '0;
        end else if ((state == 2'd3) && frame_start) begin
            if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + BW'(1'b1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        flash_cnt_d  = flash_cnt_q;
        flash_mask_d = flash_mask_q;
        // A load takes precedence over a same-cycle frame decrement
        if ((state == 2'd0) || (state == 2'd2)) begin
            flash_cnt_d = '0;
        end else if (clear_pulse) begin
            flash_mask_d = clear_mask;
            flash_cnt_d  = FW'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - FW'(1'b1);
        end else begin
            flash_cnt_d = flash_cnt_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_q <= 2'd0;
            blink_on_q   <= 1'b0;
            frame_cnt_q  <= '0;
            flash_cnt_q  <= '0;
            flash_mask_q <= '0;
        end else begin
            prev_state_q <= prev_state_d;
            blink_on_q   <= blink_on_d;
            frame_cnt_q  <= frame_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_mask_q <= flash_mask_d;
        end
    end

    assign tile_addr   = tile_addr_q;
    assign ovl_addr    = ovl_addr_q;
    assign ovl_sel     = ovl_sel_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;

endmodule
